// File: rtl/hazard_pkg.sv
// Shared opcode constants, forward-select encoding and sequencer state for the
// ID-stage hazard sequencer.
package hazard_pkg;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_AND  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_LW   = 6;
    localparam int unsigned OP_SW   = 7;
    localparam int unsigned OP_LDW  = 8;
    localparam int unsigned OP_SDW  = 9;
    // Opcodes 0..13 read rs as operand A.
    localparam int unsigned OP_A_LAST = 13;
    // Opcodes 0..3 are R-type and read rt as operand B.
    localparam int unsigned OP_R_LAST = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_DW2 = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding comparator for one operand source: EX beats MEM beats WB.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 4
) (
    input  logic [REG_W-1:0] idx_i,
    input  logic             used_i,
    input  logic             regwr_ex_i,
    input  logic [REG_W-1:0] rd_ex_i,
    input  logic             regwr_mem_i,
    input  logic [REG_W-1:0] rd_mem_i,
    input  logic             regwr_wb_i,
    input  logic [REG_W-1:0] rd_wb_i,
    output fwd_sel_t         sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (used_i) begin
            if (regwr_ex_i && (rd_ex_i == idx_i)) begin
                sel_o = FWD_EX;
            end else if (regwr_mem_i && (rd_mem_i == idx_i)) begin
                sel_o = FWD_MEM;
            end else if (regwr_wb_i && (rd_wb_i == idx_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// ID-stage hazard unit: operand forwarding, load-use bubbles, two-round LDW/SDW
// sequencing and odd-Rd exceptions with a saturating exception counter.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W     = 4,
    parameter int unsigned OPC_W     = 6,
    parameter int unsigned EXC_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPC_W-1:0]     opcode_id,
    input  logic [REG_W-1:0]     rs_id,
    input  logic [REG_W-1:0]     rt_id,
    input  logic [REG_W-1:0]     rd_id,
    input  logic                 regwr_ex,
    input  logic                 memrd_ex,
    input  logic [REG_W-1:0]     rd_ex,
    input  logic                 regwr_mem,
    input  logic [REG_W-1:0]     rd_mem,
    input  logic                 regwr_wb,
    input  logic [REG_W-1:0]     rd_wb,
    output logic                 stall,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b,
    output logic                 exception,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic [EXC_CNT_W-1:0] exc_cnt
);

    state_t               state_q, state_d;
    logic [EXC_CNT_W-1:0] exc_cnt_q, exc_cnt_d;

    logic             is_ldw, is_sdw, dw_op, odd_rd_exc;
    logic             use_a, use_b;
    logic [REG_W-1:0] src_b;
    logic             load_use;
    fwd_sel_t         fwd_a, fwd_b;

    logic stall_raw, exc_raw, pc_en_raw, ifid_en_raw, exc_inc;

    assign is_ldw     = (opcode_id == OPC_W'(OP_LDW));
    assign is_sdw     = (opcode_id == OPC_W'(OP_SDW));
    assign dw_op      = is_ldw | is_sdw;
    assign odd_rd_exc = dw_op & rd_id[0];
    assign use_a      = (opcode_id <= OPC_W'(OP_A_LAST));

    // SDW stores rd in round 1 and rd+1 (wrapping) in round 2.
    always_comb begin
        use_b = 1'b0;
        src_b = rt_id;
        if (opcode_id <= OPC_W'(OP_R_LAST)) begin
            use_b = 1'b1;
        end else if (opcode_id == OPC_W'(OP_SW)) begin
            use_b = 1'b1;
            src_b = rd_id;
        end else if (is_sdw) begin
            use_b = 1'b1;
            src_b = (state_q == ST_DW2) ? rd_id + REG_W'(1) : rd_id;
        end
    end

    fwd_select #(
        .REG_W (REG_W)
    ) u_fwd_a (
        .idx_i       (rs_id),
        .used_i      (use_a),
        .regwr_ex_i  (regwr_ex),
        .rd_ex_i     (rd_ex),
        .regwr_mem_i (regwr_mem),
        .rd_mem_i    (rd_mem),
        .regwr_wb_i  (regwr_wb),
        .rd_wb_i     (rd_wb),
        .sel_o       (fwd_a)
    );

    fwd_select #(
        .REG_W (REG_W)
    ) u_fwd_b (
        .idx_i       (src_b),
        .used_i      (use_b),
        .regwr_ex_i  (regwr_ex),
        .rd_ex_i     (rd_ex),
        .regwr_mem_i (regwr_mem),
        .rd_mem_i    (rd_mem),
        .regwr_wb_i  (regwr_wb),
        .rd_wb_i     (rd_wb),
        .sel_o       (fwd_b)
    );

    assign load_use = memrd_ex & regwr_ex &
                      ((use_a & (rd_ex == rs_id)) | (use_b & (rd_ex == src_b)));

    always_comb begin
        state_d     = state_q;
        stall_raw   = 1'b0;
        exc_raw     = 1'b0;
        pc_en_raw   = 1'b1;
        ifid_en_raw = 1'b1;
        exc_inc     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (odd_rd_exc) begin
                    exc_raw = 1'b1;
                    exc_inc = 1'b1;
                end else if (load_use) begin
                    stall_raw   = 1'b1;
                    pc_en_raw   = 1'b0;
                    ifid_en_raw = 1'b0;
                end else if (dw_op) begin
                    stall_raw   = 1'b1;
                    pc_en_raw   = 1'b0;
                    ifid_en_raw = 1'b0;
                    state_d     = ST_DW2;
                end
            end
            ST_DW2: begin
                // Round 1 already validated Rd, so no exception check here.
                if (load_use) begin
                    stall_raw   = 1'b1;
                    pc_en_raw   = 1'b0;
                    ifid_en_raw = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign exc_cnt_d = (exc_inc && (exc_cnt_q != '1)) ? exc_cnt_q + EXC_CNT_W'(1) : exc_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            exc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    // All outputs are forced low while reset is held.
    assign stall     = rst_n & stall_raw;
    assign exception = rst_n & exc_raw;
    assign pc_en     = rst_n & pc_en_raw;
    assign ifid_en   = rst_n & ifid_en_raw;
    assign forward_a = rst_n ? fwd_a : FWD_RF;
    assign forward_b = rst_n ? fwd_b : FWD_RF;
    assign exc_cnt   = rst_n ? exc_cnt_q : '0;

endmodule
